stream_test_engine: RTL and testbench

STREAM_TEST_ENGINE -- requirements
Module: stream_test_engine

---
 rtl/stream_test_engine.sv | 189 ++++++++++++++++++
 tb/tb_stream_test_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_test_engine.sv
// Stream test engine: INC/PRBS/CONST traffic generator plus matching checker, counters and error LED.
// Latency: mode takes effect one cycle after it changes; tx_data advances the cycle after a handshake.
// Backpressure: tx_valid never depends on tx_ready and tx_data holds while stalled; rx_ready is 1 after reset.
module stream_test_engine #(
  parameter int unsigned TX_DEXP   = 3,
  parameter int unsigned RX_DEXP   = 0,
  parameter int unsigned LED_HOLD  = 50000000,
  parameter logic [30:0] SEED      = 31'h0000_0001,
  parameter logic [7:0]  CONST_PAT = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rstn_async,
  input  logic [1:0]              mode,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [(8<<TX_DEXP)-1:0] tx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic [(8<<RX_DEXP)-1:0] rx_data,
  output logic                    locked,
  output logic [15:0]             err_count,
  output logic [31:0]             tx_count,
  output logic [31:0]             rx_count,
  output logic                    led
);

  localparam int unsigned TW = 8 << TX_DEXP;
  localparam int unsigned RW = 8 << RX_DEXP;
  localparam int unsigned LW = (LED_HOLD < 2) ? 1 : $clog2(LED_HOLD + 1);

  localparam logic [1:0] M_INC   = 2'd0;
  localparam logic [1:0] M_PRBS  = 2'd1;
  localparam logic [1:0] M_CONST = 2'd2;
  localparam logic [1:0] M_OFF   = 2'd3;

  localparam logic [TW-1:0] CONST_TX = {(TW/8){CONST_PAT}};
  localparam logic [RW-1:0] CONST_RX = {(RW/8){CONST_PAT}};

  // x^31 + x^28 + 1 Fibonacci step
  function automatic logic [30:0] lfsr_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  // LFSR state repeated across the word, truncated to the word width
  function automatic logic [TW-1:0] prbs_tx(input logic [30:0] s);
    logic [TW-1:0] r;
    for (int i = 0; i < TW; i++) r[i] = s[i % 31];
    return r;
  endfunction

  function automatic logic [RW-1:0] prbs_rx(input logic [30:0] s);
    logic [RW-1:0] r;
    for (int i = 0; i < RW; i++) r[i] = s[i % 31];
    return r;
  endfunction

  logic          started_q;
  logic [1:0]    mode_q;
  logic [TW-1:0] tx_data_q, tx_data_d;
  logic [30:0]   lfsr_tx_q, lfsr_tx_d;
  logic [30:0]   lfsr_rx_q, lfsr_rx_d;
  logic          locked_q, locked_d;
  logic [RW-1:0] expect_q, expect_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [31:0]   tx_count_q, tx_count_d;
  logic [31:0]   rx_count_q, rx_count_d;
  logic [LW-1:0] led_cnt_q, led_cnt_d;

  logic tx_hs, rx_hs, mode_chg, err_evt;

  // Outputs: started_q gates valid/ready so nothing moves on the first edge after reset
  always_comb begin
    tx_valid  = started_q && (mode_q != M_OFF);
    rx_ready  = started_q;
    tx_data   = (mode_q == M_PRBS) ? prbs_tx(lfsr_tx_q) : tx_data_q;
    locked    = locked_q;
    err_count = err_count_q;
    tx_count  = tx_count_q;
    rx_count  = rx_count_q;
    led       = (led_cnt_q == '0);
  end

  // Handshakes and mode-change detect; the first edge after reset counts as a mode change
  always_comb begin
    tx_hs    = tx_valid && tx_ready;
    rx_hs    = rx_valid && started_q;
    mode_chg = !started_q || (mode != mode_q);
  end

  // Generator next state; reinitialisation on mode change beats a same-cycle advance
  always_comb begin
    tx_data_d = tx_data_q;
    lfsr_tx_d = lfsr_tx_q;
    if (mode_chg) begin
      case (mode)
        M_INC:   tx_data_d = '0;
        M_PRBS:  lfsr_tx_d = SEED;
        M_CONST: tx_data_d = CONST_TX;
        default: ;
      endcase
    end else if (tx_hs) begin
      case (mode_q)
        M_INC:   tx_data_d = tx_data_q + TW'(1);
        M_PRBS:  lfsr_tx_d = lfsr_step(lfsr_tx_q);
        default: ;
      endcase
    end
  end

  // Checker next state; the received word is judged against the mode in force this cycle
  always_comb begin
    err_evt   = 1'b0;
    locked_d  = locked_q;
    expect_d  = expect_q;
    lfsr_rx_d = lfsr_rx_q;
    if (rx_hs) begin
      case (mode_q)
        M_INC: begin
          if (locked_q && (rx_data != expect_q)) err_evt = 1'b1;
          expect_d = rx_data + RW'(1);
          locked_d = 1'b1;
        end
        M_PRBS: begin
          if (rx_data != prbs_rx(lfsr_rx_q)) err_evt = 1'b1;
          lfsr_rx_d = lfsr_step(lfsr_rx_q);
        end
        M_CONST: begin
          if (rx_data != CONST_RX) err_evt = 1'b1;
        end
        default: ;
      endcase
    end
    if (mode_chg) begin
      case (mode)
        M_INC:   locked_d = 1'b0;
        M_PRBS: begin
          locked_d  = 1'b1;
          lfsr_rx_d = SEED;
        end
        M_CONST: locked_d = 1'b1;
        default: locked_d = 1'b0;
      endcase
    end
  end

  // Counters and LED hold timer; an error reloads the timer even when it is still running
  always_comb begin
    tx_count_d  = tx_count_q + {31'd0, tx_hs};
    rx_count_d  = rx_count_q + {31'd0, rx_hs};
    err_count_d = err_count_q;
    led_cnt_d   = led_cnt_q;
    if (err_evt) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      led_cnt_d = LW'(LED_HOLD);
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - LW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      started_q   <= 1'b0;
      mode_q      <= M_INC;
      tx_data_q   <= '0;
      lfsr_tx_q   <= SEED;
      lfsr_rx_q   <= SEED;
      locked_q    <= 1'b0;
      expect_q    <= '0;
      err_count_q <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      led_cnt_q   <= '0;
    end else begin
      started_q   <= 1'b1;
      mode_q      <= mode;
      tx_data_q   <= tx_data_d;
      lfsr_tx_q   <= lfsr_tx_d;
      lfsr_rx_q   <= lfsr_rx_d;
      locked_q    <= locked_d;
      expect_q    <= expect_d;
      err_count_q <= err_count_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      led_cnt_q   <= led_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_test_engine.sv
// Bench for stream_test_engine: three TX widths (64/8/32 bits) share one stimulus stream and 8-bit RX.
// Expected behaviour comes from a handshake-index reference model and a precomputed PRBS sequence.
// Inputs change 1 time unit after the rising edge; outputs are compared at that point.
module tb_stream_test_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_async;
  logic [1:0] mode;
  logic       tx_ready, rx_valid;
  logic [7:0] rx_data;

  logic        tx_valid_a, tx_valid_b, tx_valid_c;
  logic [63:0] tx_data_a;
  logic [7:0]  tx_data_b;
  logic [31:0] tx_data_c;
  logic        rx_ready_a, rx_ready_b, rx_ready_c;
  logic        locked_a, locked_b, locked_c;
  logic [15:0] err_a, err_b, err_c;
  logic [31:0] txc_a, txc_b, txc_c, rxc_a, rxc_b, rxc_c;
  logic        led_a, led_b, led_c;

  stream_test_engine #(.TX_DEXP(3), .RX_DEXP(0), .LED_HOLD(8)) u_a (
    .clk(clk), .rstn_async(rstn_async), .mode(mode),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready), .tx_data(tx_data_a),
    .rx_valid(rx_valid), .rx_ready(rx_ready_a), .rx_data(rx_data),
    .locked(locked_a), .err_count(err_a), .tx_count(txc_a), .rx_count(rxc_a), .led(led_a));

  stream_test_engine #(.TX_DEXP(0), .RX_DEXP(0), .LED_HOLD(8)) u_b (
    .clk(clk), .rstn_async(rstn_async), .mode(mode),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready), .tx_data(tx_data_b),
    .rx_valid(rx_valid), .rx_ready(rx_ready_b), .rx_data(rx_data),
    .locked(locked_b), .err_count(err_b), .tx_count(txc_b), .rx_count(rxc_b), .led(led_b));

  stream_test_engine #(.TX_DEXP(2), .RX_DEXP(0), .LED_HOLD(8)) u_c (
    .clk(clk), .rstn_async(rstn_async), .mode(mode),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready), .tx_data(tx_data_c),
    .rx_valid(rx_valid), .rx_ready(rx_ready_c), .rx_data(rx_data),
    .locked(locked_c), .err_count(err_c), .tx_count(txc_c), .rx_count(rxc_c), .led(led_c));

  int n_vec = 0;
  int n_bad = 0;

  // PRBS sequence: prbs_seq[k] is the LFSR state after k steps from seed 1
  logic [30:0] prbs_seq [1024];

  // Reference model: words counted since the stream was (re)initialised
  bit              m_started;
  logic [1:0]      m_mode;
  longint unsigned m_tx_idx;
  int              m_rx_idx;
  bit              m_locked;
  logic [7:0]      m_last;
  int unsigned     m_txc, m_rxc;
  int              m_err;
  int              m_led_left;

  function automatic logic [63:0] rep64(input logic [30:0] s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = s[i % 31];
    return r;
  endfunction

  function automatic logic [30:0] seq_at(input longint unsigned k);
    if (k < 1024) return prbs_seq[int'(k)];
    return 31'bx;
  endfunction

  function automatic logic [63:0] exp_tx();
    case (m_mode)
      2'd0:    return m_tx_idx;
      2'd1:    return rep64(seq_at(m_tx_idx));
      default: return {8{8'hA5}};
    endcase
  endfunction

  // The RX word the checker would accept next
  function automatic logic [7:0] good_rx();
    logic [63:0] w;
    case (m_mode)
      2'd0:    return m_locked ? m_last + 8'd1 : 8'($urandom);
      2'd1:    begin w = rep64(seq_at(longint'(m_rx_idx))); return w[7:0]; end
      2'd2:    return 8'hA5;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_mode = 2'd0; m_tx_idx = 0; m_rx_idx = 0; m_locked = 0;
    m_last = 8'd0; m_txc = 0; m_rxc = 0; m_err = 0; m_led_left = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven
  task automatic model_edge();
    bit txh, rxh, err;
    logic [7:0] want;
    if (!rstn_async) return;
    txh = m_started && (m_mode != 2'd3) && tx_ready;
    rxh = m_started && rx_valid;
    err = 0;
    if (rxh) begin
      want = good_rx();
      case (m_mode)
        2'd0: begin
          if (m_locked && rx_data !== want) err = 1;
          m_locked = 1;
          m_last = rx_data;
        end
        2'd1: begin
          if (rx_data !== want) err = 1;
          m_rx_idx++;
        end
        2'd2: if (rx_data !== 8'hA5) err = 1;
        default: ;
      endcase
    end
    if (txh) m_tx_idx++;
    if (txh) m_txc++;
    if (rxh) m_rxc++;
    if (err) begin
      if (m_err < 65535) m_err++;
      m_led_left = 8;
    end else if (m_led_left > 0) begin
      m_led_left--;
    end
    if (!m_started || mode != m_mode) begin
      m_mode = mode;
      m_tx_idx = 0;
      m_rx_idx = 0;
      m_locked = (mode == 2'd1) || (mode == 2'd2);
    end
    m_started = 1;
  endtask

  task automatic check_all();
    logic [63:0] et;
    bit ev;
    ev = m_started && (m_mode != 2'd3);
    chk("tx_valid_a", 64'(tx_valid_a), 64'(ev));
    chk("tx_valid_b", 64'(tx_valid_b), 64'(ev));
    chk("tx_valid_c", 64'(tx_valid_c), 64'(ev));
    if (m_mode != 2'd3) begin
      et = exp_tx();
      chk("tx_data_a", tx_data_a, et);
      chk("tx_data_b", 64'(tx_data_b), 64'(et[7:0]));
      chk("tx_data_c", 64'(tx_data_c), 64'(et[31:0]));
    end
    chk("rx_ready", 64'(rx_ready_a), 64'(m_started));
    chk("locked", 64'(locked_a), 64'(m_locked));
    chk("err_count", 64'(err_a), 64'(m_err));
    chk("err_count_c", 64'(err_c), 64'(m_err));
    chk("tx_count_a", 64'(txc_a), 64'(m_txc));
    chk("tx_count_b", 64'(txc_b), 64'(m_txc));
    chk("rx_count", 64'(rxc_a), 64'(m_rxc));
    chk("led", 64'(led_a), 64'(m_led_left == 0));
  endtask

  task automatic cyc(input bit do_chk = 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    rx_valid = 1'b0;
    cyc();
  endtask

  initial begin
    logic [7:0] v39 [4];
    int e0;
    prbs_seq[0] = 31'h0000_0001;
    for (int k = 1; k < 1024; k++)
      prbs_seq[k] = {prbs_seq[k-1][29:0], prbs_seq[k-1][30] ^ prbs_seq[k-1][27]};

    rstn_async = 1'b0; mode = 2'd0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    model_reset();
    #12;
    check_all();
    chk("reset_led", 64'(led_a), 64'd1);
    @(negedge clk) rstn_async = 1'b1;
    cyc();

    // INC counting with backpressure hold
    tx_ready = 1'b1;
    repeat (4) cyc();
    tx_ready = 1'b0;
    repeat (3) cyc();
    chk("inc_tx_count", 64'(txc_a), 64'd4);
    chk("inc_hold_data", tx_data_a, 64'd4);

    // INC RX lock, one gap error, LED hold window
    v39 = '{8'h10, 8'h11, 8'h13, 8'h14};
    rx_valid = 1'b1;
    foreach (v39[i]) begin
      rx_data = v39[i];
      cyc();
    end
    rx_valid = 1'b0;
    chk("inc_locked", 64'(locked_a), 64'd1);
    chk("inc_err_one", 64'(err_a), 64'd1);
    repeat (12) cyc();

    // INC RX wrap FF -> 00 after relock, and 8-bit TX wrap on u_b
    set_mode(2'd3);
    set_mode(2'd0);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hFF; cyc();
    rx_data = 8'h00; cyc();
    rx_valid = 1'b0;
    chk("inc_wrap_noerr", 64'(err_a), 64'd1);
    repeat (258) cyc();
    tx_ready = 1'b0;

    // Randomised traffic in every mode
    for (int mi = 0; mi < 4; mi++) begin
      set_mode(2'(mi));
      for (int n = 0; n < 200; n++) begin
        tx_ready = 1'($urandom_range(0, 1));
        rx_valid = ($urandom_range(0, 2) != 0);
        rx_data  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : good_rx();
        cyc();
      end
    end

    // PRBS: 100 words with word 50 corrupted
    set_mode(2'd0);
    set_mode(2'd1);
    e0 = m_err;
    rx_valid = 1'b1;
    for (int w = 1; w <= 100; w++) begin
      rx_data = good_rx() ^ ((w == 50) ? 8'h01 : 8'h00);
      cyc();
    end
    rx_valid = 1'b0;
    cyc();
    chk("prbs_one_err", 64'(err_a), 64'(e0 + 1));

    // CONST word, OFF mode, INC->PRBS restart under load
    set_mode(2'd2);
    chk("const_c", 64'(tx_data_c), 64'h0000_0000_A5A5_A5A5);
    tx_ready = 1'b1;
    cyc();
    set_mode(2'd3);
    chk("off_valid", 64'(tx_valid_a), 64'd0);
    e0 = m_err;
    rx_valid = 1'b1;
    repeat (5) begin
      rx_data = 8'($urandom);
      cyc();
    end
    chk("off_unchecked", 64'(err_a), 64'(e0));
    set_mode(2'd0);
    repeat (5) cyc();
    set_mode(2'd1);
    chk("prbs_restart", tx_data_a, rep64(31'h0000_0001));
    cyc();

    // Error counter saturation
    tx_ready = 1'b0;
    set_mode(2'd2);
    rx_valid = 1'b1;
    rx_data = 8'h00;
    repeat (65540) cyc(1'b0);
    rx_valid = 1'b0;
    cyc();
    chk("err_saturated", 64'(err_a), 64'hFFFF);

    // Asynchronous reset mid-stream
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    repeat (3) cyc();
    #2 rstn_async = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) cyc();
    @(negedge clk) rstn_async = 1'b1;
    mode = 2'd0;
    rx_valid = 1'b0;
    repeat (4) cyc();
    chk("post_reset_txc", 64'(txc_a), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
